// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, LCD register field positions and opcode constants for lcd_ctrl.
package lcd_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT, ST_INIT} lcd_state_e;
  localparam int LCD_ON_BIT = 31;
  localparam int LCD_RS_BIT = 10;
  localparam int LCD_DATA_MSB = 7;
  localparam int LCD_DATA_LSB = 0;
  localparam int CMD_W = 9;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;
  localparam int INIT_LEN = 4;
  // Power-up sequence, first command in the low byte: function set, display on, clear, entry mode.
  localparam logic [8*INIT_LEN-1:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
  endfunction
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: DEPTH x W synchronous command FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: queues LSU LCD register stores and replays them on an HD44780 bus with setup/pulse/hold/exec timing.
// Define LCD_INIT_SEQ_EN to issue the power-up command sequence automatically after reset.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC = 2,
  parameter int EXEC_CYC = 1850,
  parameter int LONG_EXEC_CYC = 76000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_LCD,
  input  logic        lcd_wr,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        busy,
  output logic        full,
  output logic        overflow
);
  localparam int CW = $clog2(LONG_EXEC_CYC + 1);
`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e RST_STATE = ST_INIT;
  logic [2:0] idx_q;
`else
  localparam lcd_state_e RST_STATE = ST_IDLE;
`endif
  lcd_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0] data_q;
  logic rs_q, en_q, on_q, ovf_q;
  logic [CMD_W-1:0] fifo_rdata;
  logic fifo_empty, fifo_full, fifo_pop;
  assign fifo_pop = state_q == ST_IDLE && !fifo_empty;
  lcd_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lcd_wr),
    .wdata_i ({io_LCD[LCD_RS_BIT], io_LCD[LCD_DATA_MSB:LCD_DATA_LSB]}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign lcd_data = data_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_en = en_q;
  assign lcd_on = on_q;
  assign busy = !fifo_empty || state_q != ST_IDLE;
  assign full = fifo_full;
  assign overflow = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q <= '0;
      data_q <= '0;
      rs_q <= 1'b0;
      en_q <= 1'b0;
      on_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      idx_q <= '0;
`endif
    end else begin
      if (lcd_wr) on_q <= io_LCD[LCD_ON_BIT];
      if (lcd_wr && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            data_q <= fifo_rdata[7:0];
            rs_q <= fifo_rdata[8];
            cnt_q <= CW'(SETUP_CYC);
            state_q <= ST_SETUP;
          end
        end
`ifdef LCD_INIT_SEQ_EN
        ST_INIT: begin
          data_q <= INIT_ROM[{idx_q[1:0], 3'b000} +: 8];
          rs_q <= 1'b0;
          on_q <= 1'b1;
          idx_q <= idx_q + 3'd1;
          cnt_q <= CW'(SETUP_CYC);
          state_q <= ST_SETUP;
        end
`endif
        ST_SETUP: begin
          cnt_q <= cnt_q == CW'(1) ? CW'(PULSE_CYC) : cnt_q - CW'(1);
          en_q <= cnt_q == CW'(1);
          state_q <= cnt_q == CW'(1) ? ST_PULSE : ST_SETUP;
        end
        ST_PULSE: begin
          cnt_q <= cnt_q == CW'(1) ? CW'(HOLD_CYC) : cnt_q - CW'(1);
          en_q <= cnt_q != CW'(1);
          state_q <= cnt_q == CW'(1) ? ST_HOLD : ST_PULSE;
        end
        ST_HOLD: begin
          if (cnt_q == CW'(1)) begin
            cnt_q <= is_long_cmd(rs_q, data_q) ? CW'(LONG_EXEC_CYC) : CW'(EXEC_CYC);
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_q == CW'(1)) begin
`ifdef LCD_INIT_SEQ_EN
            state_q <= idx_q < 3'(INIT_LEN) ? ST_INIT : ST_IDLE;
`else
            state_q <= ST_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: per-cycle comparison of lcd_ctrl against a command-timeline model, with directed and random stimulus.
module tb_lcd_ctrl;
  localparam int S = 2, P = 4, H = 2, E = 10, L = 50, D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] io_LCD = '0;
  logic lcd_wr = 1'b0;
  logic [7:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_en, lcd_on, busy, full, overflow;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;
  lcd_ctrl #(.DEPTH(D), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(E), .LONG_EXEC_CYC(L)) dut (
    .clk(clk), .rst(rst), .io_LCD(io_LCD), .lcd_wr(lcd_wr), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on), .busy(busy), .full(full), .overflow(overflow)
  );
  always #5 clk = ~clk;
  // Model: each command is a timeline of cycles counted from its pop cycle (k=0).
  logic [8:0] mq[$];
  logic [8:0] cur;
  bit m_act = 0;
  int m_k = 0, m_tot = 0;
  logic [7:0] m_data = '0;
  logic m_rs = 0, m_on = 0, m_ovf = 0;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_act = 0; m_k = 0; m_data = '0; m_rs = 0; m_on = 0; m_ovf = 0;
    end else begin
      if (m_act) begin
        m_k++;
        if (m_k == m_tot) m_act = 0;
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        m_rs = cur[8]; m_data = cur[7:0];
        m_act = 1; m_k = 1;
        m_tot = 1 + S + P + H + ((!cur[8] && cur[7:0] >= 1 && cur[7:0] <= 3) ? L : E);
      end
      if (lcd_wr) begin
        m_on = io_LCD[31];
        if (mq.size() < D) mq.push_back({io_LCD[10], io_LCD[7:0]});
        else m_ovf = 1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("lcd_data", lcd_data, m_data);
      chk("lcd_rs", lcd_rs, m_rs);
      chk("lcd_rw", lcd_rw, 0);
      chk("lcd_en", lcd_en, m_act && m_k > S && m_k <= S + P);
      chk("lcd_on", lcd_on, m_on);
      chk("busy", busy, m_act || mq.size() > 0);
      chk("full", full, mq.size() == D);
      chk("overflow", overflow, m_ovf);
    end
  end
  task automatic wr(input logic [31:0] w);
    io_LCD = w; lcd_wr = 1'b1;
    @(negedge clk);
    lcd_wr = 1'b0;
  endtask
  task automatic do_rst();
    rst = 1'b1; lcd_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic idle_wait();
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("idle_timeout", 1, 0);
  endtask
  task automatic measure(input string nm, input logic [31:0] w, input int exp_busy, input int exp_en);
    int nb = 0, ne = 0;
    idle_wait();
    wr(w);
    while (busy && nb < 500) begin
      nb++;
      if (lcd_en) ne++;
      @(negedge clk);
    end
    chk({nm, "_busy_len"}, nb, exp_busy);
    chk({nm, "_en_len"}, ne, exp_en);
  endtask
  initial begin
    int n;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_en", lcd_en, 0);
    chk("rst_data", lcd_data, 0);
    // Single write and exec-time lengths.
    measure("single", 32'h8000_0441, 19, 4);
    chk("single_data", lcd_data, 8'h41);
    chk("single_rs", lcd_rs, 1);
    chk("single_on", lcd_on, 1);
    measure("clear", 32'h0000_0001, 59, 4);
    measure("home", 32'h0000_0002, 59, 4);
    measure("fnset", 32'h0000_0038, 19, 4);
    measure("rs_data01", 32'h0000_0401, 19, 4);
    // Five writes while a command is executing: fifth dropped.
    wr(32'h8000_0038);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) wr(32'h8000_0400 | (32'h61 + i));
    chk("five_full", full, 1);
    chk("five_ovf", overflow, 1);
    idle_wait();
    chk("five_ovf_sticky", overflow, 1);
    // Write on the exact cycle the FSM pops from a full FIFO.
    do_rst();
    chk("rst_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) wr(32'h0000_0430 + i);
    n = 0;
    while (!(!m_act && mq.size() == D) && n < 500) begin @(negedge clk); n++; end
    chk("popfull_reach", n < 500, 1);
    wr(32'h0000_0441);
    chk("popfull_ovf", overflow, 0);
    chk("popfull_full", full, 1);
    idle_wait();
    // Reset during PULSE.
    wr(32'h8000_0438); wr(32'h8000_0439);
    n = 0;
    while (!lcd_en && n < 100) begin @(negedge clk); n++; end
    chk("pulse_reach", lcd_en, 1);
    do_rst();
    chk("midrst_en", lcd_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_full", full, 0);
    measure("after_rst", 32'h8000_0441, 19, 4);
    // Random traffic.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 999) == 0) do_rst();
      else if ($urandom_range(0, 9) == 0) begin
        logic [7:0] d;
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
        wr({1'($urandom), 20'h0, 1'($urandom), 2'b0, d});
      end else @(negedge clk);
    end
    idle_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
